spi_responder: RTL

SPI_RESPONDER -- requirements
Module: spi_responder

---
 rtl/spi_responder_pkg.sv | 18 +
 rtl/spi_responder_sync.sv | 34 +++
 rtl/spi_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI register responder.
// Used by spi_responder (optional SPI_RESPONDER_AUTOINC_EN build macro lives there).
package spi_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_OPORT = 3'd0;
    localparam logic [2:0] ADDR_ID    = 3'd6;
    localparam logic [2:0] ADDR_IPORT = 3'd7;

    localparam int RW_BIT = 7;

endpackage

// File: rtl/spi_responder_sync.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
// Reset value is chosen per signal so an idle bus produces no spurious edges.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder fronting an 8-entry register file (OPORT, scratch, ID, IPORT).
// Build macro SPI_RESPONDER_AUTOINC_EN: multi-byte frames step through consecutive addresses.
//   state   | meaning
//   IDLE    | deselected, or waiting for CSN high-then-low after reset
//   CMD     | shifting in the command byte
//   DATA    | transferring a data byte for r_addr
//   DONE    | frame finished, extra bytes ignored until CSN rises
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter logic [7:0] OPORT_RST = 8'h00,
    parameter logic [7:0] ID        = 8'hA5
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       SPI_SCK,
    input  logic       SPI_CSN,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic [7:0] IPORT,
    output logic [7:0] OPORT,
    output logic       WSTB,
    output logic [2:0] WADDR
);

    logic w_sck, w_sck_rise, w_sck_fall;
    logic w_csn, w_csn_rise, w_csn_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .i_clk(CLK), .i_res(RES), .i_async(SPI_SCK),
        .o_sync(w_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync #(.RST_VAL(1'b1)) u_sync_csn (
        .i_clk(CLK), .i_res(RES), .i_async(SPI_CSN),
        .o_sync(w_csn), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(CLK), .i_res(RES), .i_async(SPI_MOSI),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sck, w_csn_rise, w_csn_fall, w_mosi_rise, w_mosi_fall};

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic [2:0] r_addr;
    logic       r_rw;
    logic       r_miso;
    logic       r_wstb;
    logic [2:0] r_waddr;
    logic [7:0] r_regs [0:5];
    logic [1:0] r_settle;
    logic       r_armed;

    logic [2:0] w_cmd_addr;
    logic [7:0] w_rd_cmd;
    logic [7:0] w_byte_in;

    function automatic logic [7:0] f_reg_read(input logic [2:0] a);
        case (a)
            3'd0:       f_reg_read = r_regs[0];
            3'd1:       f_reg_read = r_regs[1];
            3'd2:       f_reg_read = r_regs[2];
            3'd3:       f_reg_read = r_regs[3];
            3'd4:       f_reg_read = r_regs[4];
            3'd5:       f_reg_read = r_regs[5];
            ADDR_ID:    f_reg_read = ID;
            default:    f_reg_read = IPORT;
        endcase
    endfunction

    assign w_cmd_addr = {r_shift[1:0], w_mosi};
    assign w_byte_in  = {r_shift[6:0], w_mosi};

    always_comb begin
        w_rd_cmd = f_reg_read(w_cmd_addr);
    end

`ifdef SPI_RESPONDER_AUTOINC_EN
    logic [2:0] w_next_addr;
    logic [7:0] w_rd_next;

    assign w_next_addr = r_addr + 3'd1;

    always_comb begin
        w_rd_next = f_reg_read(w_next_addr);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_shift  <= 8'h00;
            r_addr   <= 3'd0;
            r_rw     <= 1'b0;
            r_miso   <= 1'b0;
            r_wstb   <= 1'b0;
            r_waddr  <= 3'd0;
            r_regs[0] <= OPORT_RST;
            for (int i = 1; i < 6; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_settle <= 2'd3;
            r_armed  <= 1'b0;
        end else begin
            r_wstb <= 1'b0;

            // Synchronizer outputs still show their reset value for a couple of
            // cycles; only a CSN-high seen after that may re-arm the responder.
            if (r_settle != 2'd0) begin
                r_settle <= r_settle - 2'd1;
            end else if (w_csn) begin
                r_armed <= 1'b1;
            end

            if (w_csn) begin
                r_state <= ST_IDLE;
                r_cnt   <= 3'd0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_armed) begin
                            r_state <= ST_CMD;
                            r_cnt   <= 3'd0;
                            r_shift <= 8'h00;
                        end
                    end

                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_shift <= w_byte_in;
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_state <= ST_DATA;
                                r_rw    <= r_shift[RW_BIT-1];
                                r_addr  <= w_cmd_addr;
                                if (r_shift[RW_BIT-1]) begin
                                    r_shift <= w_rd_cmd;
                                    r_miso  <= w_rd_cmd[7];
                                end
                            end
                        end
                    end

                    ST_DATA: begin
                        if (w_sck_rise) begin
                            r_shift <= w_byte_in;
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                if (!r_rw && (r_addr < ADDR_ID)) begin
                                    r_regs[r_addr] <= w_byte_in;
                                    r_wstb         <= 1'b1;
                                    r_waddr        <= r_addr;
                                end
`ifdef SPI_RESPONDER_AUTOINC_EN
                                r_addr <= w_next_addr;
                                if (r_rw) begin
                                    r_shift <= w_rd_next;
                                    r_miso  <= w_rd_next[7];
                                end
`else
                                r_state <= ST_DONE;
                                r_miso  <= 1'b0;
`endif
                            end
                        end else if (w_sck_fall) begin
                            r_miso <= r_rw & r_shift[7];
                        end
                    end

                    default: begin
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SPI_MISO = r_miso;
    assign OPORT    = r_regs[ADDR_OPORT];
    assign WSTB     = r_wstb;
    assign WADDR    = r_waddr;

endmodule
